// File: rtl/mdu_unit_if.sv
// Multiply/divide unit operand, control and result bundle.
// Latency: none (wires only).
// Backpressure: none; the requester honours start||busy via the hazard unit.
// Ports: op/rs_val/rt_val/flush from the pipeline; start/busy/hi/lo/rdata back.
interface mdu_unit_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             flush;
    logic             start;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] rdata;

    modport master (
        output op, rs_val, rt_val, flush,
        input  start, busy, hi, lo, rdata
    );

    modport slave (
        input  op, rs_val, rt_val, flush,
        output start, busy, hi, lo, rdata
    );
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide/accumulate unit owning the HI/LO register pair.
// Latency: MULT_LAT cycles for multiply-class ops, DIV_LAT for divides; mthi/mtlo one edge.
// Backpressure: none; busy is exported and ops arriving while busy are dropped.
// Ports: clk, reset (async active-low), bus (slave side of mdu_unit_if).
module mdu_unit #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic       clk,
    input  logic       reset,
    mdu_unit_if.slave  bus
);
    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;

    // How the pending result lands in {HI,LO} when the countdown expires.
    typedef enum logic [1:0] {WR_NONE, WR_SET, WR_ADD, WR_SUB} wr_mode_t;

    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     hi_q, lo_q;
    logic [2*WIDTH-1:0]   pend_res, next_res;
    wr_mode_t             pend_mode, next_mode;

    logic                 start_cls, is_div, is_signed;
    logic [2*WIDTH-1:0]   a_ext, b_ext, prod;
    logic                 neg_a, neg_b;
    logic [WIDTH-1:0]     mag_a, mag_b, dvsr, q_mag, r_mag, quo, rem;

    always_comb begin
        start_cls = 1'b0;
        is_div    = 1'b0;
        is_signed = 1'b0;
        next_mode = WR_NONE;
        case (bus.op)
            OP_MULT:  begin start_cls = 1'b1; is_signed = 1'b1; next_mode = WR_SET; end
            OP_MULTU: begin start_cls = 1'b1;                   next_mode = WR_SET; end
            OP_DIV:   begin start_cls = 1'b1; is_signed = 1'b1; is_div = 1'b1; next_mode = WR_SET; end
            OP_DIVU:  begin start_cls = 1'b1; is_div = 1'b1;    next_mode = WR_SET; end
            OP_MADD:  begin start_cls = 1'b1; is_signed = 1'b1; next_mode = WR_ADD; end
            OP_MADDU: begin start_cls = 1'b1;                   next_mode = WR_ADD; end
            OP_MSUB:  begin start_cls = 1'b1; is_signed = 1'b1; next_mode = WR_SUB; end
            OP_MSUBU: begin start_cls = 1'b1;                   next_mode = WR_SUB; end
            default:  ;
        endcase
        // A zero divisor still occupies the unit but must not disturb HI/LO.
        if (is_div && (bus.rt_val == '0))
            next_mode = WR_NONE;
    end

    // Full-width product: sign- or zero-extend both operands to 2*WIDTH first.
    always_comb begin
        a_ext = {{WIDTH{is_signed & bus.rs_val[WIDTH-1]}}, bus.rs_val};
        b_ext = {{WIDTH{is_signed & bus.rt_val[WIDTH-1]}}, bus.rt_val};
        prod  = a_ext * b_ext;
    end

    // Signed divide via magnitudes: quotient truncates toward zero, remainder
    // follows the dividend. MIN/-1 falls out naturally as quotient MIN, remainder 0.
    always_comb begin
        neg_a = is_signed & bus.rs_val[WIDTH-1];
        neg_b = is_signed & bus.rt_val[WIDTH-1];
        mag_a = neg_a ? (~bus.rs_val + 1'b1) : bus.rs_val;
        mag_b = neg_b ? (~bus.rt_val + 1'b1) : bus.rt_val;
        dvsr  = (mag_b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
        q_mag = mag_a / dvsr;
        r_mag = mag_a % dvsr;
        quo   = (neg_a ^ neg_b) ? (~q_mag + 1'b1) : q_mag;
        rem   = neg_a ? (~r_mag + 1'b1) : r_mag;
        next_res = is_div ? {rem, quo} : prod;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_res  <= '0;
            pend_mode <= WR_NONE;
        end else if (cnt == '0) begin
            if (start_cls && !bus.flush) begin
                cnt       <= is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
                pend_res  <= next_res;
                pend_mode <= next_mode;
            end else if (bus.op == OP_MTHI) begin
                hi_q <= bus.rs_val;
            end else if (bus.op == OP_MTLO) begin
                lo_q <= bus.rs_val;
            end
        end else if (bus.flush) begin
            cnt <= '0;
        end else begin
            cnt <= cnt - 1'b1;
            // Accumulate ops read HI/LO here, at write time, not at start.
            if (cnt == CW'(1)) begin
                case (pend_mode)
                    WR_SET:  {hi_q, lo_q} <= pend_res;
                    WR_ADD:  {hi_q, lo_q} <= {hi_q, lo_q} + pend_res;
                    WR_SUB:  {hi_q, lo_q} <= {hi_q, lo_q} - pend_res;
                    default: ;
                endcase
            end
        end
    end

    assign bus.start = start_cls;
    assign bus.busy  = (cnt != '0);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.rdata = (bus.op == OP_MFHI) ? hi_q :
                       (bus.op == OP_MFLO) ? lo_q : '0;
endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit against a behavioural HI/LO model.
// Latency: checks busy every cycle of each operation and results after completion.
// Backpressure: issues a new op only once the previous one has drained.
module tb_mdu_unit;
    localparam int W  = 32;
    localparam int ML = 5;
    localparam int DL = 10;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mdu_unit_if #(.WIDTH(W)) bus ();
    mdu_unit #(.WIDTH(W), .MULT_LAT(ML), .DIV_LAT(DL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    logic [W-1:0] mhi = '0;
    logic [W-1:0] mlo = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lat_of(input logic [3:0] o);
        return (o == 4'd3 || o == 4'd4) ? DL : ML;
    endfunction

    function automatic bit is_start(input logic [3:0] o);
        return (o >= 4'd1 && o <= 4'd4) || (o >= 4'd9 && o <= 4'd12);
    endfunction

    // Reference: plain 64-bit arithmetic on the architectural HI/LO pair.
    task automatic model_apply(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sp, up;
        logic [63:0] acc;
        int sa, sb;
        sp  = longint'($signed(a)) * longint'($signed(b));
        up  = longint'(a) * longint'(b);
        acc = {mhi, mlo};
        sa  = $signed(a);
        sb  = $signed(b);
        case (o)
            4'd1:  {mhi, mlo} = sp;
            4'd2:  {mhi, mlo} = up;
            4'd9:  {mhi, mlo} = acc + sp;
            4'd10: {mhi, mlo} = acc + up;
            4'd11: {mhi, mlo} = acc - sp;
            4'd12: {mhi, mlo} = acc - up;
            4'd3: begin
                if (b == 0) ;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    mlo = 32'h8000_0000; mhi = 0;
                end else begin
                    mlo = sa / sb; mhi = sa % sb;
                end
            end
            4'd4: if (b != 0) begin mlo = a / b; mhi = a % b; end
            default: ;
        endcase
    endtask

    // Called at a negedge: hold the op across one rising edge, return at the next negedge.
    task automatic launch(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.op = o; bus.rs_val = a; bus.rt_val = b;
        #1 check("start", bus.start, is_start(o));
        @(negedge clk);
        bus.op = 4'd0;
    endtask

    // Checks busy for run cycles first..lat, then busy low and HI/LO against the model.
    task automatic drain(input string tag, input int first, input int lat);
        for (int i = first; i <= lat; i++) begin
            check({tag, "_busy"}, bus.busy, 1'b1);
            @(negedge clk);
        end
        check({tag, "_idle"}, bus.busy, 1'b0);
        check({tag, "_hi"}, bus.hi, mhi);
        check({tag, "_lo"}, bus.lo, mlo);
    endtask

    task automatic do_op(input string tag, input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        launch(o, a, b);
        model_apply(o, a, b);
        drain(tag, 1, lat_of(o));
    endtask

    task automatic move_to(input logic [3:0] o, input logic [W-1:0] a);
        bus.op = o; bus.rs_val = a;
        @(negedge clk);
        bus.op = 4'd0;
        if (o == 4'd7) mhi = a; else mlo = a;
        check("mt_hi", bus.hi, mhi);
        check("mt_lo", bus.lo, mlo);
    endtask

    task automatic read_back();
        bus.op = 4'd5; #1 check("mfhi", bus.rdata, mhi);
        bus.op = 4'd6; #1 check("mflo", bus.rdata, mlo);
        bus.op = 4'd0; #1 check("rdata_none", bus.rdata, 0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return W'($urandom_range(0, 7));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        logic [3:0] ops [10];
        logic [3:0] ro;
        logic [W-1:0] ra, rb;
        ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd10, 4'd11, 4'd12, 4'd7, 4'd8};
        bus.op = 4'd0; bus.rs_val = '0; bus.rt_val = '0; bus.flush = 1'b0;

        #1;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        do_op("mult", 4'd1, 32'hFFFF_FFFF, 32'd2);
        check("mult_hi_const", bus.hi, 32'hFFFF_FFFF);
        check("mult_lo_const", bus.lo, 32'hFFFF_FFFE);
        do_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2);
        check("multu_hi_const", bus.hi, 32'h1);
        read_back();

        do_op("div", 4'd3, -32'sd7, 32'd2);
        check("div_lo_const", bus.lo, 32'hFFFF_FFFD);
        check("div_hi_const", bus.hi, 32'hFFFF_FFFF);
        do_op("divu0", 4'd4, 32'd7, 32'd0);
        check("divu0_hi_const", bus.hi, 32'hFFFF_FFFF);
        do_op("divmin", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        check("divmin_lo_const", bus.lo, 32'h8000_0000);
        check("divmin_hi_const", bus.hi, 32'h0);

        move_to(4'd7, 32'h0);
        move_to(4'd8, 32'hFFFF_FFFF);
        do_op("madd", 4'd9, 32'd1, 32'd1);
        check("madd_hi_const", bus.hi, 32'h1);
        check("madd_lo_const", bus.lo, 32'h0);
        do_op("msubu", 4'd12, 32'd1, 32'd1);
        check("msubu_lo_const", bus.lo, 32'hFFFF_FFFF);

        // Flush in run cycle 3: no write, busy low after that edge.
        launch(4'd1, 32'd3, 32'd5);
        check("fl3_busy1", bus.busy, 1'b1);
        @(negedge clk); @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        drain("flush3", ML + 1, ML);

        // Flush in the final cycle suppresses the write.
        launch(4'd2, 32'd9, 32'd9);
        repeat (ML - 1) @(negedge clk);
        check("flend_busy", bus.busy, 1'b1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        drain("flushend", ML + 1, ML);

        // Flush together with a start while idle: nothing starts.
        bus.op = 4'd1; bus.flush = 1'b1; bus.rs_val = 32'd4; bus.rt_val = 32'd4;
        @(negedge clk);
        bus.op = 4'd0; bus.flush = 1'b0;
        drain("flushstart", ML + 1, ML);

        // mthi while busy is ignored; mfhi afterwards sees the multiply's HI.
        launch(4'd1, 32'h1234_5678, 32'h100);
        model_apply(4'd1, 32'h1234_5678, 32'h100);
        check("mtb_busy1", bus.busy, 1'b1);
        bus.op = 4'd7; bus.rs_val = 32'h1234;
        @(negedge clk);
        bus.op = 4'd0;
        drain("mthi_busy", 2, ML);
        read_back();

        // Async reset mid-divide, away from any clock edge.
        launch(4'd3, 32'd100, 32'd3);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_busy", bus.busy, 1'b0);
        check("arst_hi", bus.hi, 0);
        check("arst_lo", bus.lo, 0);
        mhi = '0; mlo = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_op("post_rst", 4'd1, 32'd3, 32'd4);

        // Randomized ops, issued back-to-back as soon as busy drops.
        for (int n = 0; n < 40; n++) begin
            ro = ops[$urandom_range(0, 9)];
            ra = pick();
            rb = pick();
            if (ro == 4'd7 || ro == 4'd8)
                move_to(ro, ra);
            else
                do_op("rand", ro, ra, rb);
            if (n % 4 == 0) read_back();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
